// File: rtl/fetch_decode_front.sv
// Front end of the 16-bit pipelined CPU: PC generator, IF/ID register and instruction decoder
// with EX/MEM operand forwarding.
module fetch_decode_front #(
  parameter int unsigned DW   = 16,
  parameter int unsigned RAW  = 4,
  parameter int unsigned OPW  = 4,
  parameter int unsigned SELW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   rom_data_i,
  output logic [DW-1:0]   pc,
  output logic            rom_ce_o,
  output logic [DW-1:0]   id_pc,
  output logic [DW-1:0]   id_inst,
  input  logic [DW-1:0]   reg1_data_in,
  input  logic [DW-1:0]   reg2_data_in,
  output logic            reg1_read,
  output logic            reg2_read,
  output logic [RAW-1:0]  reg1_addr,
  output logic [RAW-1:0]  reg2_addr,
  input  logic            ex_wreg_f,
  input  logic [RAW-1:0]  ex_wd_f,
  input  logic [DW-1:0]   ex_wdata_f,
  input  logic            mem_wreg_f,
  input  logic [RAW-1:0]  mem_wd_f,
  input  logic [DW-1:0]   mem_wdata_f,
  output logic [OPW-1:0]  aluop,
  output logic [SELW-1:0] alusel,
  output logic [DW-1:0]   reg1_data_out,
  output logic [DW-1:0]   reg2_data_out,
  output logic [RAW-1:0]  wd_o,
  output logic            wreg_o
);

  logic [3:0]     op;
  logic [RAW-1:0] rd, rs, rt;
  logic [DW-1:0]  imm;

  assign op = id_inst[15:12];
  assign rd = id_inst[11:8];
  assign rs = id_inst[7:4];
  assign rt = id_inst[3:0];

  // pc clears on the edge after rom_ce_o drops, so a mid-run reset takes two edges to reach 0.
  always_ff @(posedge clk) begin
    rom_ce_o <= ~rst;
    if (!rom_ce_o) pc <= '0;
    else           pc <= pc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc   <= '0;
      id_inst <= '0;
    end else begin
      id_pc   <= pc;
      id_inst <= rom_data_i;
    end
  end

  // EX result is newer than MEM, so it wins when both target the same register.
  function automatic logic [DW-1:0] fwd(input logic [RAW-1:0] addr, input logic [DW-1:0] rf);
    if (ex_wreg_f && ex_wd_f == addr)        return ex_wdata_f;
    else if (mem_wreg_f && mem_wd_f == addr) return mem_wdata_f;
    else                                     return rf;
  endfunction

  always_comb begin
    aluop         = '0;
    alusel        = '0;
    reg1_read     = 1'b0;
    reg2_read     = 1'b0;
    wreg_o        = 1'b0;
    imm           = '0;
    reg1_addr     = '0;
    reg2_addr     = '0;
    wd_o          = '0;
    reg1_data_out = '0;
    reg2_data_out = '0;
    if (!rst) begin
      case (op)
        4'h1: begin aluop = 4'd1; alusel = 3'd1; reg1_read = 1'b1; reg2_read = 1'b1; end
        4'h2: begin aluop = 4'd2; alusel = 3'd1; reg1_read = 1'b1; reg2_read = 1'b1; end
        4'h3: begin aluop = 4'd3; alusel = 3'd2; reg1_read = 1'b1; reg2_read = 1'b1; end
        4'h4: begin aluop = 4'd4; alusel = 3'd2; reg1_read = 1'b1; reg2_read = 1'b1; end
        4'h5: begin aluop = 4'd5; alusel = 3'd2; reg1_read = 1'b1; reg2_read = 1'b1; end
        4'h6: begin
          aluop = 4'd6; alusel = 3'd3; reg1_read = 1'b1;
          imm   = {{(DW-4){1'b0}}, rt};
        end
        4'h7: begin
          aluop = 4'd7; alusel = 3'd3; reg1_read = 1'b1;
          imm   = {{(DW-4){1'b0}}, rt};
        end
        4'h8: begin
          aluop = 4'd1; alusel = 3'd1; reg1_read = 1'b1;
          imm   = {{(DW-4){rt[3]}}, rt};
        end
        4'h9: begin
          aluop = 4'd4; alusel = 3'd2;
          imm   = {{(DW-8){1'b0}}, id_inst[7:0]};
        end
        default: ;
      endcase
      wreg_o = (op >= 4'h1) && (op <= 4'h9);
    end
    if (reg1_read) reg1_addr = rs;
    if (reg2_read) reg2_addr = rt;
    if (wreg_o)    wd_o      = rd;
    reg1_data_out = reg1_read ? fwd(reg1_addr, reg1_data_in) : '0;
    reg2_data_out = reg2_read ? fwd(reg2_addr, reg2_data_in) : imm;
  end

endmodule

// File: tb/tb_fetch_decode_front.sv
// Bench for fetch_decode_front: table-driven decode model checked every cycle plus directed
// literal expectations.
module tb_fetch_decode_front;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rom_data_i;
  logic [15:0] pc, id_pc, id_inst;
  logic        rom_ce_o;
  logic [15:0] reg1_data_in, reg2_data_in;
  logic        reg1_read, reg2_read;
  logic [3:0]  reg1_addr, reg2_addr;
  logic        ex_wreg_f, mem_wreg_f;
  logic [3:0]  ex_wd_f, mem_wd_f;
  logic [15:0] ex_wdata_f, mem_wdata_f;
  logic [3:0]  aluop;
  logic [2:0]  alusel;
  logic [15:0] reg1_data_out, reg2_data_out;
  logic [3:0]  wd_o;
  logic        wreg_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  fetch_decode_front dut (
    .clk(clk), .rst(rst), .rom_data_i(rom_data_i), .pc(pc), .rom_ce_o(rom_ce_o),
    .id_pc(id_pc), .id_inst(id_inst), .reg1_data_in(reg1_data_in),
    .reg2_data_in(reg2_data_in), .reg1_read(reg1_read), .reg2_read(reg2_read),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .ex_wreg_f(ex_wreg_f), .ex_wd_f(ex_wd_f),
    .ex_wdata_f(ex_wdata_f), .mem_wreg_f(mem_wreg_f), .mem_wd_f(mem_wd_f),
    .mem_wdata_f(mem_wdata_f), .aluop(aluop), .alusel(alusel),
    .reg1_data_out(reg1_data_out), .reg2_data_out(reg2_data_out), .wd_o(wd_o), .wreg_o(wreg_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode property tables; immediate kind: 0 none, 1 zero-ext rt, 2 sign-ext rt, 3 zero-ext byte.
  int t_op[16]  = '{0, 1, 2, 3, 4, 5, 6, 7, 1, 4, 0, 0, 0, 0, 0, 0};
  int t_sel[16] = '{0, 1, 1, 2, 2, 2, 3, 3, 1, 2, 0, 0, 0, 0, 0, 0};
  int t_r1[16]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
  int t_r2[16]  = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int t_wr[16]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  int t_imm[16] = '{0, 0, 0, 0, 0, 0, 1, 1, 2, 3, 0, 0, 0, 0, 0, 0};

  logic [15:0] m_pc = 16'd0, m_id_pc = 16'd0, m_id_inst = 16'd0;
  logic        m_ce = 1'b0;

  always @(posedge clk) begin
    logic [15:0] nxt;
    nxt       = m_ce ? m_pc + 16'd1 : 16'd0;
    m_id_pc   = rst ? 16'd0 : m_pc;
    m_id_inst = rst ? 16'd0 : rom_data_i;
    m_pc      = nxt;
    m_ce      = !rst;
  end

  function automatic logic [15:0] pick(input logic [3:0] a, input logic [15:0] rf);
    if (ex_wreg_f && ex_wd_f == a)   return ex_wdata_f;
    if (mem_wreg_f && mem_wd_f == a) return mem_wdata_f;
    return rf;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      int o;
      logic [3:0] rs, rt;
      logic [15:0] e1, e2;
      o  = rst ? 0 : int'(m_id_inst[15:12]);
      rs = m_id_inst[7:4];
      rt = m_id_inst[3:0];
      e1 = t_r1[o] != 0 ? pick(rs, reg1_data_in) : 16'd0;
      case (t_imm[o])
        1: e2 = {12'd0, rt};
        2: e2 = {{12{rt[3]}}, rt};
        3: e2 = {8'd0, m_id_inst[7:0]};
        default: e2 = 16'd0;
      endcase
      if (t_r2[o] != 0) e2 = pick(rt, reg2_data_in);
      chk("pc", pc, m_pc);
      chk("rom_ce", rom_ce_o, m_ce);
      chk("id_pc", id_pc, m_id_pc);
      chk("id_inst", id_inst, m_id_inst);
      chk("aluop", aluop, t_op[o]);
      chk("alusel", alusel, t_sel[o]);
      chk("reg1_read", reg1_read, t_r1[o]);
      chk("reg2_read", reg2_read, t_r2[o]);
      chk("reg1_addr", reg1_addr, t_r1[o] != 0 ? rs : 4'd0);
      chk("reg2_addr", reg2_addr, t_r2[o] != 0 ? rt : 4'd0);
      chk("wreg_o", wreg_o, t_wr[o]);
      chk("wd_o", wd_o, t_wr[o] != 0 ? m_id_inst[11:8] : 4'd0);
      chk("reg1_data_out", reg1_data_out, e1);
      chk("reg2_data_out", reg2_data_out, e2);
    end
  end

  // Call at posedge+1: presents inst on the ROM bus and returns once it sits in IF/ID.
  task automatic load(input logic [15:0] inst);
    rom_data_i = inst;
    @(posedge clk); #1;
  endtask

  task automatic fwd_set(input logic ew, input logic [3:0] ed, input logic [15:0] edat,
                         input logic mw, input logic [3:0] md, input logic [15:0] mdat);
    ex_wreg_f = ew; ex_wd_f = ed; ex_wdata_f = edat;
    mem_wreg_f = mw; mem_wd_f = md; mem_wdata_f = mdat;
    #1;
  endtask

  initial begin
    rst = 1'b1; rom_data_i = 16'h0000;
    reg1_data_in = 16'd0; reg2_data_in = 16'd0;
    ex_wreg_f = 1'b0; ex_wd_f = 4'd0; ex_wdata_f = 16'd0;
    mem_wreg_f = 1'b0; mem_wd_f = 4'd0; mem_wdata_f = 16'd0;

    // T1 reset
    rom_data_i = 16'h3443;
    @(posedge clk); @(posedge clk); #1;
    chk("t1_pc", pc, 16'd0);
    chk("t1_ce", rom_ce_o, 1'b0);
    chk("t1_inst", id_inst, 16'd0);
    chk("t1_wreg", wreg_o, 1'b0);
    chk("t1_aluop", aluop, 4'd0);
    cmp_en = 1'b1;

    // T2 fetch
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t2_ce", rom_ce_o, 1'b1);
    chk("t2_pc0", pc, 16'd0);
    @(posedge clk); #1;
    chk("t2_pc1", pc, 16'd1);
    chk("t2_idpc0", id_pc, 16'd0);
    @(posedge clk); #1;
    chk("t2_pc2", pc, 16'd2);
    chk("t2_idpc1", id_pc, 16'd1);

    // T3 AND, no forwarding match
    reg1_data_in = 16'd4; reg2_data_in = 16'd5;
    fwd_set(1'b1, 4'd1, 16'd8, 1'b1, 4'd2, 16'd16);
    chk("t3_aluop", aluop, 4'd3);
    chk("t3_alusel", alusel, 3'd2);
    chk("t3_a1", reg1_addr, 4'd4);
    chk("t3_a2", reg2_addr, 4'd3);
    chk("t3_d1", reg1_data_out, 16'd4);
    chk("t3_d2", reg2_data_out, 16'd5);
    chk("t3_wd", wd_o, 4'd4);
    chk("t3_wreg", wreg_o, 1'b1);

    // T4 forwarding from both stages
    load(16'h1312);
    chk("t4_aluop", aluop, 4'd1);
    chk("t4_d1", reg1_data_out, 16'd8);
    chk("t4_d2", reg2_data_out, 16'd16);

    // T5 EX priority over MEM
    fwd_set(1'b1, 4'd1, 16'd8, 1'b1, 4'd1, 16'd16);
    load(16'h1311);
    chk("t5_d1", reg1_data_out, 16'd8);
    chk("t5_d2", reg2_data_out, 16'd8);
    fwd_set(1'b0, 4'd1, 16'd8, 1'b1, 4'd1, 16'd16);
    chk("t5_d1_mem", reg1_data_out, 16'd16);
    chk("t5_d2_mem", reg2_data_out, 16'd16);

    // T6 immediates and invalid opcode
    load(16'h8A2F);
    chk("t6_addi_d2", reg2_data_out, 16'hFFFF);
    chk("t6_addi_r2", reg2_read, 1'b0);
    load(16'h93C5);
    chk("t6_li_d1", reg1_data_out, 16'd0);
    chk("t6_li_d2", reg2_data_out, 16'h00C5);
    chk("t6_li_wd", wd_o, 4'd3);
    load(16'h6A27);
    chk("t6_sll_d2", reg2_data_out, 16'h0007);
    load(16'hF123);
    chk("t6_inv_wreg", wreg_o, 1'b0);
    chk("t6_inv_d1", reg1_data_out, 16'd0);
    chk("t6_inv_aluop", aluop, 4'd0);

    // A few more patterns checked by the model only
    load(16'h2F0E); load(16'h5123); load(16'h7BAD); load(16'h4000);

    // Reset mid-run: decode clears immediately, pc reaches 0 on the second edge
    rst = 1'b1; #1;
    chk("rst_dec_now", aluop, 4'd0);
    chk("rst_wreg_now", wreg_o, 1'b0);
    @(posedge clk); #1;
    chk("rst_ce", rom_ce_o, 1'b0);
    @(posedge clk); #1;
    chk("rst_pc", pc, 16'd0);
    rst = 1'b0;
    load(16'h3443); load(16'h1312);
    @(posedge clk); #1;

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
